alu_dispatch_unit: RTL and testbench
====================================

# alu_dispatch_unit

Sequential front end for the combinational ArithmeticLogicUnit. It accepts one decoded instruction at a time over a valid/ready handshake, reads operands from an internal register file, and drives the ALU input ports. It then captures the ALU's OutDest and OutFlags and writes them back into the register file and a committed flags register. The unit sits between instruction decode and the ALU, and is the only writer of architectural registers and flags.

## Interface
- DataWidth, InstructionSetPkg value (16 in bench): register and ALU datapath width.
- ImmediateWidth, InstructionSetPkg value (8 in bench): immediate field width.
- RegCount, 8: number of general registers.
- RegAddrWidth, $clog2(RegCount): register index width.
- Clock  input  1  single clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  instruction fields valid.
- InReady  output  1  unit can accept an instruction.
- InOp  input  eOperation  operation to execute.
- InDestReg  input  RegAddrWidth  destination register index, also the second operand.
- InSrcReg  input  RegAddrWidth  source register index.
- InImm  input  signed ImmediateWidth  immediate.
- AluOperation  output  eOperation  registered; goes to ALU Operation.
- AluInSrc / AluInDest  output  signed DataWidth  registered operands to the ALU.
- AluInImm  output  signed ImmediateWidth  registered immediate.
- AluInFlags  output  sFlags  the committed flags register.
- AluOutDest  input  signed DataWidth  ALU result.
- AluOutFlags  input  sFlags  ALU flags result.
- Flags  output  sFlags  committed flags; same signal as AluInFlags.
- Done  output  1  one-cycle pulse after writeback.
- DbgAddr  input  RegAddrWidth  register file debug read index.
- DbgData  output  DataWidth  combinational RegFile[DbgAddr].

## Operation
- The FSM has four states: IDLE, READ, EXEC, WRITE. InReady = (state == IDLE).
- **IDLE:** when InValid && InReady, latch InOp, InDestReg, InSrcReg and InImm into the instruction register, then go to READ. If InValid is low, stay in IDLE.
- **READ:** load AluInSrc <= RegFile[src] and AluInDest <= RegFile[dest]. AluOperation and AluInImm come from the instruction register. Go to EXEC.
- **EXEC:** the ALU settles combinationally. Capture AluOutDest into Result and AluOutFlags into FlagsNext. Go to WRITE.
- **WRITE:** RegFile[dest] <= Result and Flags <= FlagsNext. Set Done <= 1 and go to IDLE.
- Every opcode writes back, including opcodes the ALU does not implement; the ALU's default output of zero is written.
- Src == Dest is legal. Both operands then carry the same register value.
- Input fields are ignored while InReady is low. No queueing.
- Only the ALU generates flag values. The unit never modifies them itself.

## Timing
- Let an accept occur at rising edge N.
- Operands are valid on the ALU ports after edge N+1.
- The ALU result is sampled at edge N+2.
- The register file and Flags update at edge N+3.
- Done is high from edge N+3 to edge N+4. InReady is high again from edge N+3.
- Back-to-back: an instruction may be accepted at edge N+4, while Done is high. Its READ at edge N+5 sees the value written at N+3, so there is no hazard.
- Sustained throughput is one instruction per 4 cycles.
- DbgData reflects a write from the edge it occurs.
- Reset, asynchronous:
  - state = IDLE, InReady = 1, Done = 0;
  - all RegFile entries = 0, Flags = all zero;
  - AluInSrc, AluInDest, AluInImm, Result = 0;
  - AluOperation and the latched op = encoding 0.
- Reset asserted mid-instruction aborts it. No register or flag write occurs and Done does not pulse.

## Test plan
- **Reset then load:** reset, then LIL dest R1 imm 5. Required: accept at edge N, Done high for edge N+3 to N+4, DbgData(R1) = 0x0005, Flags unchanged at 0.
- **Move and dependency:** MOVE dest R2 src R1, issued back-to-back in the Done cycle. Required: R2 = 0x0005, accepted at N+4, Done at N+7.
- **ADC with flags:** R1 = 0x7FFF, R2 = 0x0001, Carry = 0, then ADC dest R2 src R1. Required: R2 = 0x8000, Overflow = 1, Negative = 1, Zero = 0, Carry = 0; AluInFlags shows the new flags from N+3.
- **Busy ignore:** hold InValid high with differing fields during READ/EXEC/WRITE. Required: InReady = 0 in those states, exactly one instruction executes, and only the fields latched at acceptance are used.
- **Reset mid-op:** assert Reset during EXEC of NOR dest R3 src R1. Required: R3 = 0, Flags = 0, no Done pulse, InReady = 1 immediately.
- **ROR carry chain:** Carry = 1, R4 = 0x0002, ROR dest R4 src R4. Required: R4 = 0x8001, Carry = 0.

Source files
------------

// File: rtl/alu_dispatch_unit.sv
// Sequential front end for the combinational ALU: accepts one instruction per
// valid/ready handshake, reads operands, drives the ALU and writes results back.
package InstructionSetPkg;
  localparam int DataWidth      = 16;
  localparam int ImmediateWidth = 8;

  typedef enum logic [3:0] {
    OpLil  = 4'd0,
    OpLih  = 4'd1,
    OpMove = 4'd2,
    OpAdc  = 4'd3,
    OpNor  = 4'd4,
    OpRor  = 4'd5,
    OpRsvd = 4'd15
  } eOperation;

  typedef struct packed {
    logic Carry;
    logic Zero;
    logic Negative;
    logic Overflow;
  } sFlags;
endpackage

module alu_dispatch_unit
  import InstructionSetPkg::*;
#(
  parameter int DataWidth      = InstructionSetPkg::DataWidth,
  parameter int ImmediateWidth = InstructionSetPkg::ImmediateWidth,
  parameter int RegCount       = 8,
  parameter int RegAddrWidth   = $clog2(RegCount)
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             InValid,
  output logic                             InReady,
  input  eOperation                        InOp,
  input  logic        [RegAddrWidth-1:0]   InDestReg,
  input  logic        [RegAddrWidth-1:0]   InSrcReg,
  input  logic signed [ImmediateWidth-1:0] InImm,
  output eOperation                        AluOperation,
  output logic signed [DataWidth-1:0]      AluInSrc,
  output logic signed [DataWidth-1:0]      AluInDest,
  output logic signed [ImmediateWidth-1:0] AluInImm,
  output sFlags                            AluInFlags,
  input  logic signed [DataWidth-1:0]      AluOutDest,
  input  sFlags                            AluOutFlags,
  output sFlags                            Flags,
  output logic                             Done,
  input  logic        [RegAddrWidth-1:0]   DbgAddr,
  output logic        [DataWidth-1:0]      DbgData
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StExec  = 2'd2,
    StWrite = 2'd3
  } state_e;

  state_e                           state_q, state_d;
  eOperation                        op_q, op_d;
  logic        [RegAddrWidth-1:0]   dest_q, dest_d;
  logic        [RegAddrWidth-1:0]   src_q, src_d;
  logic signed [ImmediateWidth-1:0] imm_q, imm_d;
  eOperation                        alu_op_q, alu_op_d;
  logic signed [DataWidth-1:0]      alu_src_q, alu_src_d;
  logic signed [DataWidth-1:0]      alu_dest_q, alu_dest_d;
  logic signed [ImmediateWidth-1:0] alu_imm_q, alu_imm_d;
  logic signed [DataWidth-1:0]      result_q, result_d;
  sFlags                            flags_next_q, flags_next_d;
  sFlags                            flags_q, flags_d;
  logic                             done_q, done_d;
  logic signed [DataWidth-1:0]      regfile_q [RegCount];
  logic signed [DataWidth-1:0]      regfile_d [RegCount];

  // Instruction sequencing: IDLE -> READ -> EXEC -> WRITE, one instruction in flight.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dest_d       = dest_q;
    src_d        = src_q;
    imm_d        = imm_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    alu_dest_d   = alu_dest_q;
    alu_imm_d    = alu_imm_q;
    result_d     = result_q;
    flags_next_d = flags_next_q;
    flags_d      = flags_q;
    done_d       = 1'b0;
    regfile_d    = regfile_q;
    case (state_q)
      StIdle: begin
        if (InValid) begin
          op_d    = InOp;
          dest_d  = InDestReg;
          src_d   = InSrcReg;
          imm_d   = InImm;
          state_d = StRead;
        end else begin
          state_d = StIdle;
        end
      end
      StRead: begin
        alu_src_d  = regfile_q[src_q];
        alu_dest_d = regfile_q[dest_q];
        alu_op_d   = op_q;
        alu_imm_d  = imm_q;
        state_d    = StExec;
      end
      StExec: begin
        result_d     = AluOutDest;
        flags_next_d = AluOutFlags;
        state_d      = StWrite;
      end
      StWrite: begin
        // Every opcode commits, so unimplemented ops write the ALU's zero default.
        regfile_d[dest_q] = result_q;
        flags_d           = flags_next_q;
        done_d            = 1'b1;
        state_d           = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, pipeline and architectural registers; reset aborts any instruction.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      op_q         <= OpLil;
      dest_q       <= '0;
      src_q        <= '0;
      imm_q        <= '0;
      alu_op_q     <= OpLil;
      alu_src_q    <= '0;
      alu_dest_q   <= '0;
      alu_imm_q    <= '0;
      result_q     <= '0;
      flags_next_q <= '0;
      flags_q      <= '0;
      done_q       <= 1'b0;
      regfile_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dest_q       <= dest_d;
      src_q        <= src_d;
      imm_q        <= imm_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      alu_dest_q   <= alu_dest_d;
      alu_imm_q    <= alu_imm_d;
      result_q     <= result_d;
      flags_next_q <= flags_next_d;
      flags_q      <= flags_d;
      done_q       <= done_d;
      regfile_q    <= regfile_d;
    end
  end

  assign InReady      = (state_q == StIdle);
  assign AluOperation = alu_op_q;
  assign AluInSrc     = alu_src_q;
  assign AluInDest    = alu_dest_q;
  assign AluInImm     = alu_imm_q;
  assign AluInFlags   = flags_q;
  assign Flags        = flags_q;
  assign Done         = done_q;
  assign DbgData      = regfile_q[DbgAddr];

endmodule

// File: tb/tb_alu_dispatch_unit.sv
// Table-driven bench for alu_dispatch_unit with a behavioural ALU model attached.
module tb_alu_dispatch_unit;
  import InstructionSetPkg::*;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic               InValid = 1'b0;
  logic               InReady;
  eOperation          InOp = OpLil;
  logic        [2:0]  InDestReg = 3'd0;
  logic        [2:0]  InSrcReg = 3'd0;
  logic signed [7:0]  InImm = 8'sd0;
  eOperation          AluOperation;
  logic signed [15:0] AluInSrc, AluInDest, AluOutDest;
  logic signed [7:0]  AluInImm;
  sFlags              AluInFlags, AluOutFlags, Flags;
  logic               Done;
  logic        [2:0]  DbgAddr = 3'd0;
  logic        [15:0] DbgData;

  int checks = 0;
  int errors = 0;

  alu_dispatch_unit dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InOp(InOp), .InDestReg(InDestReg), .InSrcReg(InSrcReg), .InImm(InImm),
    .AluOperation(AluOperation), .AluInSrc(AluInSrc), .AluInDest(AluInDest),
    .AluInImm(AluInImm), .AluInFlags(AluInFlags), .AluOutDest(AluOutDest),
    .AluOutFlags(AluOutFlags), .Flags(Flags), .Done(Done),
    .DbgAddr(DbgAddr), .DbgData(DbgData)
  );

  always #5 Clock = ~Clock;

  // Behavioural ALU: ops that do not compute flags pass the committed flags through.
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum     = {1'b0, AluInDest} + {1'b0, AluInSrc} + {16'd0, AluInFlags.Carry};
    AluOutDest  = '0;
    AluOutFlags = '0;
    case (AluOperation)
      OpLil:  begin AluOutDest = {{8{AluInImm[7]}}, AluInImm}; AluOutFlags = AluInFlags; end
      OpLih:  begin AluOutDest = {AluInImm, AluInDest[7:0]};   AluOutFlags = AluInFlags; end
      OpMove: begin AluOutDest = AluInSrc;                     AluOutFlags = AluInFlags; end
      OpAdc: begin
        AluOutDest           = alu_sum[15:0];
        AluOutFlags.Carry    = alu_sum[16];
        AluOutFlags.Zero     = (alu_sum[15:0] == 16'd0);
        AluOutFlags.Negative = alu_sum[15];
        AluOutFlags.Overflow = (AluInDest[15] == AluInSrc[15]) && (alu_sum[15] != AluInDest[15]);
      end
      OpNor: begin
        AluOutDest           = ~(AluInDest | AluInSrc);
        AluOutFlags.Carry    = AluInFlags.Carry;
        AluOutFlags.Zero     = ((AluInDest | AluInSrc) == 16'hFFFF);
        AluOutFlags.Negative = ~(AluInDest[15] | AluInSrc[15]);
        AluOutFlags.Overflow = AluInFlags.Overflow;
      end
      OpRor: begin
        AluOutDest           = {AluInFlags.Carry, AluInDest[15:1]};
        AluOutFlags.Carry    = AluInDest[0];
        AluOutFlags.Zero     = ({AluInFlags.Carry, AluInDest[15:1]} == 16'd0);
        AluOutFlags.Negative = AluInFlags.Carry;
        AluOutFlags.Overflow = AluInFlags.Overflow;
      end
      default: begin
        AluOutDest  = '0;
        AluOutFlags = '0;
      end
    endcase
  end

  typedef struct {
    eOperation         op;
    logic [2:0]        dest;
    logic [2:0]        src;
    logic signed [7:0] imm;
    logic [15:0]       exp_val;
    logic [3:0]        exp_flags;  // {Carry, Zero, Negative, Overflow}
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input eOperation op, input logic [2:0] d, input logic [2:0] s,
                       input logic signed [7:0] imm, output int lat);
    int i;
    InOp = op; InDestReg = d; InSrcReg = s; InImm = imm; InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    lat = -1;
    i = 0;
    while (lat < 0 && i < 8) begin
      i++;
      @(posedge Clock); #1;
      if (Done) lat = i;
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    DbgAddr = a;
    #1;
    v = DbgData;
  endtask

  initial begin
    int lat;
    int extra;
    logic [15:0] v;

    vecs[0]  = '{OpLil,  3'd1, 3'd0, 8'sd5,   16'h0005, 4'b0000};
    vecs[1]  = '{OpMove, 3'd2, 3'd1, 8'sd0,   16'h0005, 4'b0000};
    vecs[2]  = '{OpLil,  3'd1, 3'd0, -8'sd1,  16'hFFFF, 4'b0000};
    vecs[3]  = '{OpLih,  3'd1, 3'd0, 8'sd127, 16'h7FFF, 4'b0000};
    vecs[4]  = '{OpLil,  3'd2, 3'd0, 8'sd1,   16'h0001, 4'b0000};
    vecs[5]  = '{OpAdc,  3'd2, 3'd1, 8'sd0,   16'h8000, 4'b0011};
    vecs[6]  = '{OpLil,  3'd5, 3'd0, -8'sd1,  16'hFFFF, 4'b0011};
    vecs[7]  = '{OpLil,  3'd6, 3'd0, 8'sd1,   16'h0001, 4'b0011};
    vecs[8]  = '{OpAdc,  3'd5, 3'd6, 8'sd0,   16'h0000, 4'b1100};
    vecs[9]  = '{OpLil,  3'd4, 3'd0, 8'sd2,   16'h0002, 4'b1100};
    vecs[10] = '{OpRor,  3'd4, 3'd4, 8'sd0,   16'h8001, 4'b0010};
    vecs[11] = '{OpNor,  3'd3, 3'd1, 8'sd0,   16'h8000, 4'b0010};
    vecs[12] = '{OpRsvd, 3'd4, 3'd2, 8'sd9,   16'h0000, 4'b0000};
    vecs[13] = '{OpAdc,  3'd1, 3'd1, 8'sd0,   16'hFFFE, 4'b0011};

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    chk("rst ready", 16'(InReady), 16'd1);
    chk("rst done", 16'(Done), 16'd0);
    chk("rst flags", 16'(Flags), 16'd0);
    chk("rst aluop", 16'(AluOperation), 16'd0);
    chk("rst alusrc", AluInSrc, 16'd0);
    chk("rst aludest", AluInDest, 16'd0);
    chk("rst aluimm", 16'($unsigned(AluInImm)), 16'd0);
    for (int r = 0; r < 8; r++) begin
      rd(3'(r), v);
      chk($sformatf("rst reg%0d", r), v, 16'd0);
    end
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Back-to-back vector stream: each issue starts in the previous Done cycle
    for (int k = 0; k < NV; k++) begin
      chk($sformatf("vec%0d ready", k), 16'(InReady), 16'd1);
      issue(vecs[k].op, vecs[k].dest, vecs[k].src, vecs[k].imm, lat);
      chk($sformatf("vec%0d latency", k), 16'(lat), 16'd3);
      chk($sformatf("vec%0d flags", k), 16'(Flags), {12'd0, vecs[k].exp_flags});
      chk($sformatf("vec%0d aluinflags", k), 16'(AluInFlags), {12'd0, vecs[k].exp_flags});
      rd(vecs[k].dest, v);
      chk($sformatf("vec%0d reg", k), v, vecs[k].exp_val);
    end
    rd(3'd2, v);
    chk("r2 after stream", v, 16'h8000);

    // Busy ignore: InValid stays high with changing fields while the unit is busy
    InOp = OpLil; InDestReg = 3'd7; InSrcReg = 3'd0; InImm = 8'sh12; InValid = 1'b1;
    @(posedge Clock); #1;
    InOp = OpLih; InDestReg = 3'd6; InSrcReg = 3'd3; InImm = 8'sh34;
    chk("busy ready read", 16'(InReady), 16'd0);
    @(posedge Clock); #1;
    chk("busy ready exec", 16'(InReady), 16'd0);
    chk("busy aluop", 16'(AluOperation), 16'(OpLil));
    chk("busy aluimm", 16'($unsigned(AluInImm)), 16'h0012);
    chk("busy aludest", AluInDest, 16'h0000);
    InOp = OpAdc; InDestReg = 3'd5;
    @(posedge Clock); #1;
    chk("busy ready write", 16'(InReady), 16'd0);
    @(posedge Clock); #1;
    InValid = 1'b0;
    chk("busy done", 16'(Done), 16'd1);
    rd(3'd7, v); chk("busy r7", v, 16'h0012);
    rd(3'd6, v); chk("busy r6", v, 16'h0001);
    rd(3'd5, v); chk("busy r5", v, 16'h0000);
    chk("busy flags", 16'(Flags), 16'b0011);
    extra = 0;
    repeat (5) begin
      @(posedge Clock); #1;
      if (Done) extra++;
    end
    chk("busy extra done", 16'(extra), 16'd0);

    // Reset asserted during EXEC aborts the instruction
    InOp = OpNor; InDestReg = 3'd3; InSrcReg = 3'd1; InImm = 8'sd0; InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    @(posedge Clock); #1;
    chk("midrst busy", 16'(InReady), 16'd0);
    Reset = 1'b1;
    #1;
    chk("midrst ready", 16'(InReady), 16'd1);
    chk("midrst done", 16'(Done), 16'd0);
    chk("midrst flags", 16'(Flags), 16'd0);
    rd(3'd3, v); chk("midrst r3", v, 16'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    extra = 0;
    repeat (5) begin
      @(posedge Clock); #1;
      if (Done) extra++;
    end
    chk("midrst no done", 16'(extra), 16'd0);
    rd(3'd3, v); chk("midrst r3 later", v, 16'd0);
    chk("midrst flags later", 16'(Flags), 16'd0);

    // Unit is functional again; most-negative immediate sign-extends
    issue(OpLil, 3'd3, 3'd0, -8'sd128, lat);
    chk("post latency", 16'(lat), 16'd3);
    rd(3'd3, v); chk("post r3", v, 16'hFF80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
